// File: rtl/uart_mem_ctrl_if.sv
// Bus bundle between the UART command engine and its environment:
// UART RX strobe, UART TX valid/ready, and the single-port RAM port A.
interface uart_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 15
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [15:0]       dina;
  logic [15:0]       douta;

  // Controller side
  modport master (
    input  rx_data, rx_valid, tx_ready, douta,
    output tx_data, tx_valid, wea, addra, dina
  );

  // UART / RAM side
  modport slave (
    output rx_data, rx_valid, tx_ready, douta,
    input  tx_data, tx_valid, wea, addra, dina
  );
endinterface

// File: rtl/uart_mem_ctrl.sv
// Host command engine: parses 'W'/'R' byte commands from the UART and
// performs 16-bit writes/reads on the RAM, returning read data as two bytes.
module uart_mem_ctrl #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  CMD_WR = 8'h57,
  parameter logic [7:0]  CMD_RD = 8'h52
) (
  input  logic           clk,
  input  logic           reset,
  uart_mem_ctrl_if.master bus,
  output logic           busy,
  output logic           cmd_err,
  output logic           rx_overrun
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned AH_W  = ADDR_W - 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE,
    S_RD_WAIT,
    S_TX_H,
    S_TX_L
  } state_e;

  state_e            state_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addra_q;
  logic [15:0]       dina_q;
  logic              wea_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        rd_lo_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              cmd_err_q;
  logic              rx_overrun_q;

  // Command FSM with registered outputs; busy_q tracks entry/exit of IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      wea_q        <= 1'b0;
      cnt_q        <= '0;
      rd_lo_q      <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      wea_q        <= 1'b0;
      cmd_err_q    <= 1'b0;
      rx_overrun_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == CMD_WR) begin
              wr_q    <= 1'b1;
              state_q <= S_ADDR_H;
              busy_q  <= 1'b1;
            end else if (bus.rx_data == CMD_RD) begin
              wr_q    <= 1'b0;
              state_q <= S_ADDR_H;
              busy_q  <= 1'b1;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        S_ADDR_H: begin
          // Address bits above ADDR_W are dropped here.
          if (bus.rx_valid) begin
            addra_q[ADDR_W-1:8] <= bus.rx_data[AH_W-1:0];
            state_q             <= S_ADDR_L;
          end
        end
        S_ADDR_L: begin
          if (bus.rx_valid) begin
            addra_q[7:0] <= bus.rx_data;
            cnt_q        <= '0;
            state_q      <= wr_q ? S_DATA_H : S_RD_WAIT;
          end
        end
        S_DATA_H: begin
          if (bus.rx_valid) begin
            dina_q[15:8] <= bus.rx_data;
            state_q      <= S_DATA_L;
          end
        end
        S_DATA_L: begin
          if (bus.rx_valid) begin
            dina_q[7:0] <= bus.rx_data;
            wea_q       <= 1'b1;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_RD_WAIT: begin
          // Capture on the (RD_LAT+1)-th edge after the address settled.
          if (cnt_q == CNT_W'(RD_LAT)) begin
            rd_lo_q    <= bus.douta[7:0];
            tx_data_q  <= bus.douta[15:8];
            tx_valid_q <= 1'b1;
            state_q    <= S_TX_H;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_TX_H: begin
          if (bus.tx_ready) begin
            tx_data_q <= rd_lo_q;
            state_q   <= S_TX_L;
          end
        end
        S_TX_L: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (bus.rx_valid && (state_q inside {S_WRITE, S_RD_WAIT, S_TX_H, S_TX_L})) begin
        rx_overrun_q <= 1'b1;
      end
    end
  end

  assign bus.wea      = wea_q;
  assign bus.addra    = addra_q;
  assign bus.dina     = dina_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = busy_q;
  assign cmd_err      = cmd_err_q;
  assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Self-checking bench for uart_mem_ctrl: directed command scenarios plus
// randomized write/read traffic against an associative-array memory model.
module tb_uart_mem_ctrl;

  localparam int unsigned RD_LAT = 1;
  localparam logic [7:0]  CMD_WR = 8'h57;
  localparam logic [7:0]  CMD_RD = 8'h52;

  logic clk = 1'b0;
  logic reset;
  logic busy, cmd_err, rx_overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int wea_cnt = 0;

  logic [15:0] ref_mem [int];
  logic [15:0] mem [0:32767];

  always #5 clk = ~clk;

  uart_mem_ctrl_if #(.ADDR_W(15)) u_if ();

  uart_mem_ctrl #(
    .ADDR_W(15), .RD_LAT(RD_LAT), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD)
  ) dut (
    .clk(clk), .reset(reset), .bus(u_if),
    .busy(busy), .cmd_err(cmd_err), .rx_overrun(rx_overrun)
  );

  // Synchronous RAM, one-cycle read latency, read-first.
  always @(posedge clk) begin
    if (u_if.wea) mem[u_if.addra] <= u_if.dina;
    u_if.douta <= mem[u_if.addra];
  end

  always @(negedge clk) if (u_if.wea === 1'b1) wea_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(input int ea);
    return ref_mem.exists(ea) ? ref_mem[ea] : 16'h0000;
  endfunction

  task automatic send1(input logic [7:0] b);
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = b;
    @(posedge clk); #1;
    u_if.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    int ea = int'(a) % 32768;
    int w0 = wea_cnt;
    send1(CMD_WR); send1(a[15:8]); send1(a[7:0]); send1(d[15:8]); send1(d[7:0]);
    n_chk++; if (u_if.wea !== 1'b1) $display("FAIL wr_wea_hi got=%b want=1", u_if.wea); else n_pass++;
    n_chk++; if (u_if.addra !== 15'(ea)) $display("FAIL wr_addra got=%h want=%h", u_if.addra, 15'(ea)); else n_pass++;
    n_chk++; if (u_if.dina !== d) $display("FAIL wr_dina got=%h want=%h", u_if.dina, d); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy_hi got=%b want=1", busy); else n_pass++;
    idle(1);
    n_chk++; if (u_if.wea !== 1'b0) $display("FAIL wr_wea_lo got=%b want=0", u_if.wea); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL wr_busy_lo got=%b want=0", busy); else n_pass++;
    n_chk++; if (wea_cnt !== w0 + 1) $display("FAIL wr_wea_cycles got=%0d want=%0d", wea_cnt - w0, 1); else n_pass++;
    ref_mem[ea] = d;
  endtask

  task automatic do_read(input logic [15:0] a, input int hold, input bit inject);
    int ea = int'(a) % 32768;
    logic [15:0] e = exp_word(ea);
    int w0 = wea_cnt;
    int waits = 0;
    send1(CMD_RD); send1(a[15:8]); send1(a[7:0]);
    n_chk++; if (u_if.addra !== 15'(ea)) $display("FAIL rd_addra got=%h want=%h", u_if.addra, 15'(ea)); else n_pass++;
    while (u_if.tx_valid !== 1'b1 && waits < 10) begin idle(1); waits++; end
    n_chk++; if (waits != int'(RD_LAT) + 1) $display("FAIL rd_latency got=%0d want=%0d", waits, RD_LAT + 1); else n_pass++;
    n_chk++; if (u_if.tx_data !== e[15:8]) $display("FAIL rd_byte_hi got=%h want=%h", u_if.tx_data, e[15:8]); else n_pass++;
    for (int i = 0; i < hold; i++) begin
      u_if.tx_ready = 1'b0;
      if (inject && i == hold / 2) begin u_if.rx_valid = 1'b1; u_if.rx_data = CMD_WR; end
      idle(1);
      u_if.rx_valid = 1'b0;
      n_chk++; if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== e[15:8]) $display("FAIL bp_stable got=%b/%h want=1/%h", u_if.tx_valid, u_if.tx_data, e[15:8]); else n_pass++;
      n_chk++; if (rx_overrun !== (inject && i == hold / 2)) $display("FAIL bp_overrun got=%b want=%b", rx_overrun, (inject && i == hold / 2)); else n_pass++;
    end
    u_if.tx_ready = 1'b1;
    idle(1);
    n_chk++; if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== e[7:0]) $display("FAIL rd_byte_lo got=%b/%h want=1/%h", u_if.tx_valid, u_if.tx_data, e[7:0]); else n_pass++;
    idle(1);
    u_if.tx_ready = 1'b0;
    n_chk++; if (u_if.tx_valid !== 1'b0) $display("FAIL rd_tx_valid_lo got=%b want=0", u_if.tx_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rd_busy_lo got=%b want=0", busy); else n_pass++;
    n_chk++; if (wea_cnt !== w0) $display("FAIL rd_no_write got=%0d want=0", wea_cnt - w0); else n_pass++;
  endtask

  task automatic check_reset_vals(input string tag);
    n_chk++;
    if ({u_if.wea, u_if.addra, u_if.dina, u_if.tx_valid, u_if.tx_data, busy, cmd_err, rx_overrun} !== '0)
      $display("FAIL %s got wea=%b addra=%h dina=%h txv=%b txd=%h busy=%b err=%b ovr=%b want all 0",
               tag, u_if.wea, u_if.addra, u_if.dina, u_if.tx_valid, u_if.tx_data, busy, cmd_err, rx_overrun);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_if.rx_valid = 1'b0; u_if.rx_data = 8'h00; u_if.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("reset_values");
  endtask

  task automatic test_write();
    do_write(16'h0001, 16'hAAAA);
  endtask

  task automatic test_read_back();
    do_read(16'h0001, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_write(16'h8005, 16'h1234);
    do_read(16'h0005, 0, 1'b0);
  endtask

  task automatic test_cmd_err();
    send1(8'h41);
    n_chk++; if (cmd_err !== 1'b1) $display("FAIL cmd_err_pulse got=%b want=1", cmd_err); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL cmd_err_idle got=%b want=0", busy); else n_pass++;
    idle(1);
    n_chk++; if (cmd_err !== 1'b0) $display("FAIL cmd_err_width got=%b want=0", cmd_err); else n_pass++;
    do_write(16'h0002, 16'h5555);
  endtask

  task automatic test_backpressure();
    int w0 = wea_cnt;
    do_read(16'h0002, 20, 1'b1);
    idle(4);
    n_chk++; if (wea_cnt !== w0 || busy !== 1'b0) $display("FAIL overrun_dropped got=%0d/%b want=0/0", wea_cnt - w0, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0 = wea_cnt;
    send1(CMD_WR); send1(8'h00); send1(8'h03); send1(8'hCC);
    n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy got=%b want=1", busy); else n_pass++;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_reset_vals("reset_mid_values");
    idle(3);
    n_chk++; if (wea_cnt !== w0) $display("FAIL reset_mid_no_write got=%0d want=0", wea_cnt - w0); else n_pass++;
    do_read(16'h0001, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] addrs [$];
    logic [15:0] a;
    for (int k = 0; k < 10; k++) begin
      a = 16'($urandom);
      addrs.push_back(a);
      do_write(a, 16'($urandom));
      idle($urandom_range(0, 2));
    end
    for (int k = 0; k < 10; k++) begin
      a = addrs[$urandom_range(0, addrs.size() - 1)];
      do_read(a, $urandom_range(0, 3), 1'b0);
      idle($urandom_range(0, 2));
    end
    do_read(16'($urandom), 1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    test_reset();
    test_write();
    test_read_back();
    test_back_to_back();
    test_cmd_err();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_mem_ctrl.md
# uart_mem_ctrl

Command engine between the UART byte stream and the 32K x 16 single-port `staticRAM`. It parses host commands arriving as received bytes. Write commands store a 16-bit word at a 15-bit address. Read commands fetch a word and return it as two bytes to the UART transmitter over a valid/ready handshake. It is the sole initiator on the RAM port A (`wea`/`addra`/`dina`/`douta`).

## Interface
Parameters:
- `ADDR_W`, 15, RAM address width; received address bits above this are discarded.
- `RD_LAT`, 1, RAM read latency in clocks from `addra` stable to `douta` valid (1..3).
- `CMD_WR`, 8'h57 ('W'), write command byte.
- `CMD_RD`, 8'h52 ('R'), read command byte.

Ports:
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock; also drives RAM `clka`.
  - `reset`  in  1  synchronous, active-high reset.
- UART receive side:
  - `rx_data`  in  8  received byte.
  - `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- UART transmit side:
  - `tx_data`  out  8  byte to transmit.
  - `tx_valid`  out  1  `tx_data` is valid; held until accepted.
  - `tx_ready`  in  1  transmitter accepts a byte when `tx_valid && tx_ready`.
- RAM port:
  - `wea`  out  1  RAM write enable.
  - `addra`  out  ADDR_W  RAM address.
  - `dina`  out  16  RAM write data.
  - `douta`  in  16  RAM read data.
- Status:
  - `busy`  out  1  high in any state other than IDLE.
  - `cmd_err`  out  1  one-cycle pulse on an unrecognised command byte.
  - `rx_overrun`  out  1  one-cycle pulse when a byte arrives in a state that cannot accept it.

## Operation
- Command formats, each field sent MSB byte first:
  - Write: `CMD_WR`, ADDR_H, ADDR_L, DATA_H, DATA_L.
  - Read: `CMD_RD`, ADDR_H, ADDR_L.
- States: IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, WRITE, RD_WAIT, TX_H, TX_L.
- IDLE:
  - `rx_valid` with `CMD_WR` -> ADDR_H, with the write flag set.
  - `rx_valid` with `CMD_RD` -> ADDR_H, with the write flag clear.
  - Any other byte -> pulse `cmd_err` and stay in IDLE.
- ADDR_H / ADDR_L: each state waits for `rx_valid`, then loads the address register {ADDR_H, ADDR_L}[ADDR_W-1:0].
  - After ADDR_L, go to DATA_H if the write flag is set, otherwise to RD_WAIT.
- DATA_H / DATA_L: load the `dina` register; after DATA_L go to WRITE.
- WRITE: `wea`=1 for exactly one cycle, then IDLE.
- RD_WAIT: count `RD_LAT`+1 cycles, capture `douta` into the read register, then go to TX_H.
- TX_H: present the high byte on `tx_data` with `tx_valid`=1. On handshake, go to TX_L.
- TX_L: present the low byte. On handshake, go to IDLE.
- `rx_valid` in WRITE, RD_WAIT, TX_H or TX_L: the byte is dropped, `rx_overrun` pulses, and the state is unchanged.
- `addra` and `dina` are registers. They hold their last values in IDLE and change only when new bytes are loaded.
- No inter-byte timeout; a partial command waits indefinitely.

## Timing
- Reset values: state IDLE; `wea`=0, `addra`=0, `dina`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `cmd_err`=0, `rx_overrun`=0.
- Reset mid-command: at the next edge the controller is in IDLE with all outputs at reset values. No write is issued and any pending `tx_valid` drops.
- Write path:
  - The DATA_L byte is sampled at edge N.
  - `wea`=1 during cycle N..N+1, with `addra`/`dina` already stable.
  - The RAM writes at edge N+1.
  - `busy` falls after edge N+1.
- Read path:
  - The ADDR_L byte is sampled at edge N; `addra` is valid from N.
  - `douta` is captured at edge N+RD_LAT+1.
  - `tx_valid` rises after that same edge.
- TX handshake:
  - `tx_data` and `tx_valid` are stable while `tx_ready`=0.
  - On a handshake, the next byte or `tx_valid`=0 appears after the same edge; there is no bubble between the high and low bytes.
- Back-to-back commands: a command byte arriving the cycle after a return to IDLE is accepted.
- Throughput: one RX byte per cycle is supported in the parse states.
- `cmd_err` and `rx_overrun` are registered pulses, high for exactly one cycle.

## Test plan
- Write: bytes 57 00 01 AA AA -> one cycle of `wea`=1 with `addra`=0001 and `dina`=AAAA; `busy` then clears.
- Read back: 52 00 01 with `tx_ready`=1 -> `tx_data` AA, then AA, on consecutive handshakes; `wea` stays 0 throughout.
- Address mask and back-to-back:
  - 57 80 05 12 34 -> `addra`=0005.
  - Then immediately 52 00 05 -> bytes 12, 34.
- Error recovery:
  - Byte 41 -> one-cycle `cmd_err` pulse, state IDLE.
  - Then 57 00 02 55 55 -> normal write of 5555 to address 0002.
- Backpressure and overrun:
  - During a read return, hold `tx_ready`=0 for 20 cycles -> `tx_valid`=1 and `tx_data` stay constant.
  - Inject `rx_valid` with byte 57 in that window -> `rx_overrun` pulses, no state change, and no later write from the dropped byte.
- Reset mid-command:
  - Send 57 00 03 CC, then assert `reset` for 1 cycle -> `wea` never asserts and outputs return to reset values.
  - Then 52 00 01 -> AA AA.
